// File: rtl/bus_copy_master_if.sv
// Simple request/grant bus with a single-beat response phase.
// Handshake: the master holds req with stable addr/we/wdata until the cycle
// gnt=1 (acceptance); the response is the first rvalid=1 after acceptance,
// and rdata/err are meaningful only in that rvalid cycle.
interface bus_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/bus_copy_master.sv
// Word-by-word memory copy engine acting as a bus initiator.
// Each word is one read then one write, never more than one transaction in
// flight. All bus outputs come straight from registers.
module bus_copy_master #(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 256
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] words_done_o,
   output logic [2:0]       dbg_state_o,
   bus_if.master            bus
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               req_q, req_d;
   logic               we_q, we_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        src_q, src_d;
   logic [31:0]        dst_q, dst_d;
   logic [31:0]        data_q, data_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [LEN_W-1:0]   words_q, words_d;
   logic               err_q, err_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               timed_out;

   // Next-state, datapath and registered-bus-output computation.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      src_d     = src_q;
      dst_d     = dst_q;
      data_d    = data_q;
      rem_d     = rem_q;
      words_d   = words_q;
      err_d     = err_q;
      timed_out = (timer_q == TMR_W'(TIMEOUT - 1));

      case (state_q)
         IDLE: begin
            if (start_i) begin
               src_d   = {src_addr_i[31:2], 2'b00};
               dst_d   = {dst_addr_i[31:2], 2'b00};
               rem_d   = len_i;
               words_d = '0;
               err_d   = 1'b0;
               if (len_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = RD_REQ;
                  req_d   = 1'b1;
                  we_d    = 1'b0;
                  addr_d  = {src_addr_i[31:2], 2'b00};
               end
            end
         end
         RD_REQ: begin
            // A grant in the timeout cycle still counts as acceptance.
            if (bus.gnt) begin
               state_d = RD_WAIT;
               req_d   = 1'b0;
            end else if (timed_out) begin
               state_d = DONE;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end
         end
         RD_WAIT: begin
            if (bus.rvalid) begin
               data_d = bus.rdata;
               if (bus.err) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = WR_REQ;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = dst_q;
                  wdata_d = bus.rdata;
               end
            end else if (timed_out) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         WR_REQ: begin
            if (bus.gnt) begin
               state_d = WR_WAIT;
               req_d   = 1'b0;
            end else if (timed_out) begin
               state_d = DONE;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end
         end
         WR_WAIT: begin
            if (bus.rvalid) begin
               if (bus.err) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  words_d = words_q + LEN_W'(1);
                  src_d   = src_q + 32'd4;
                  dst_d   = dst_q + 32'd4;
                  rem_d   = rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_d = DONE;
                  end else begin
                     state_d = RD_REQ;
                     req_d   = 1'b1;
                     we_d    = 1'b0;
                     addr_d  = src_q + 32'd4;
                  end
               end
            end else if (timed_out) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase

      // Timer restarts on every state entry and only runs in bus states.
      if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TMR_W'(1);
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         words_q <= '0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         words_q <= words_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

   assign bus.req      = req_q;
   assign bus.we       = we_q;
   assign bus.addr     = addr_q;
   assign bus.wdata    = wdata_q;
   assign busy_o       = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                         (state_q == WR_REQ) || (state_q == WR_WAIT);
   assign done_o       = (state_q == DONE);
   assign err_o        = err_q;
   assign words_done_o = words_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master with a configurable bus responder.
// Responder read data is a fixed function of address: rdata = addr ^ 32'hC0DE_0000.
module tb_bus_copy_master;
   localparam int LEN_W   = 16;
   localparam int TIMEOUT = 16;
   localparam int TW      = 65;   // {we, addr, wdata}

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_i = 1'b0;
   logic [31:0]      src_addr_i = '0;
   logic [31:0]      dst_addr_i = '0;
   logic [LEN_W-1:0] len_i = '0;
   logic             busy_o, done_o, err_o;
   logic [LEN_W-1:0] words_done_o;
   logic [2:0]       dbg_state_o;

   bus_if bus ();

   bus_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start_i),
      .src_addr_i   (src_addr_i),
      .dst_addr_i   (dst_addr_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .words_done_o (words_done_o),
      .dbg_state_o  (dbg_state_o),
      .bus          (bus.master)
   );

   // clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [TW-1:0]    exp_q[$];        // expected accepted transactions
   logic [LEN_W:0]   exp_done_q[$];   // expected {err, words_done} at done
   logic [31:0]      wmem [logic [31:0]];

   // responder configuration (written only by the main thread)
   int gnt_delay  = 0;
   int rv_delay   = 0;
   int err_on_wr  = 0;   // 1-based write index returning err, 0 = never
   bit never_gnt  = 1'b0;

   task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_wmem(input logic [31:0] a);
      if (wmem.exists(a)) return wmem[a];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [TW-1:0] rd_txn(input logic [31:0] a);
      return {1'b0, a, 32'h0};
   endfunction

   function automatic logic [TW-1:0] wr_txn(input logic [31:0] a, input logic [31:0] d);
      return {1'b1, a, d};
   endfunction

   // responder + transaction monitor, acting mid-cycle on registered DUT outputs
   int            g_cnt = 0;
   int            r_cnt = 0;
   int            wr_cnt = 0;
   bit            pend = 1'b0;
   logic [31:0]   pend_rdata = '0;
   logic          pend_err = 1'b0;
   bit            prev_wait = 1'b0;
   logic [TW-1:0] prev_snap = '0;
   always @(negedge clk) begin
      logic [TW-1:0] cur;
      logic [TW-1:0] exp;
      cur = {bus.we, bus.addr, bus.wdata};
      bus.gnt    = 1'b0;
      bus.rvalid = 1'b0;
      bus.err    = 1'b0;
      bus.rdata  = '0;
      if (rst) begin
         pend      = 1'b0;
         prev_wait = 1'b0;
         g_cnt     = gnt_delay;
      end else begin
         if (start_i) wr_cnt = 0;
         if (pend) begin
            if (r_cnt == 0) begin
               bus.rvalid = 1'b1;
               bus.rdata  = pend_rdata;
               bus.err    = pend_err;
               pend       = 1'b0;
            end else begin
               r_cnt--;
            end
         end
         if (prev_wait && bus.req) check("req_hold_stable", cur, prev_snap);
         if (!bus.req) begin
            g_cnt = gnt_delay;
         end else if (!pend && !bus.rvalid && !never_gnt) begin
            if (g_cnt == 0) begin
               bus.gnt = 1'b1;
               g_cnt   = gnt_delay;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_txn: got 0x%0h expected none", cur);
               end else begin
                  exp = exp_q.pop_front();
                  if (exp[64]) check("txn", cur, exp);
                  else check("txn", {cur[64:32], 32'h0}, exp);
               end
               pend     = 1'b1;
               r_cnt    = rv_delay;
               pend_err = 1'b0;
               if (bus.we) begin
                  wr_cnt++;
                  pend_rdata = '0;
                  if (wr_cnt == err_on_wr) pend_err = 1'b1;
                  else wmem[bus.addr] = bus.wdata;
               end else begin
                  pend_rdata = bus.addr ^ 32'hC0DE_0000;
               end
            end else begin
               g_cnt--;
            end
         end
         prev_wait = bus.req && !bus.gnt;
         prev_snap = cur;
      end
   end

   // done monitor
   always @(negedge clk) begin
      if (!rst && done_o) begin
         if (exp_done_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got err=%0b words=%0d expected none", err_o, words_done_o);
         end else begin
            check("done_status", {48'h0, err_o, words_done_o}, {48'h0, exp_done_q.pop_front()});
         end
      end
   end

   // driver tasks (called at #1 after a rising edge)
   task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      src_addr_i = s;
      dst_addr_i = d;
      len_i      = LEN_W'(n);
      start_i    = 1'b1;
      @(posedge clk); #1;
      start_i    = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int req_cycles, output bit any_busy);
      lat = 1;
      req_cycles = 0;
      any_busy = 1'b0;
      while (!done_o && lat < 500) begin
         if (bus.req) req_cycles++;
         if (busy_o) any_busy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (!done_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no done_o expected done within 500 cycles");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int lat, reqs, k;
      bit bz;

      // reset block
      repeat (3) @(posedge clk);
      #1;
      check("rst_req",   {64'h0, bus.req},   65'h0);
      check("rst_we",    {64'h0, bus.we},    65'h0);
      check("rst_addr",  {33'h0, bus.addr},  65'h0);
      check("rst_wdata", {33'h0, bus.wdata}, 65'h0);
      check("rst_flags", {62'h0, busy_o, done_o, err_o}, 65'h0);
      check("rst_words", {49'h0, words_done_o}, 65'h0);
      rst = 1'b0;
      idle(2);

      // zero-wait copy of three words
      exp_q.push_back(rd_txn(32'h1000)); exp_q.push_back(wr_txn(32'h2000, 32'hC0DE_1000));
      exp_q.push_back(rd_txn(32'h1004)); exp_q.push_back(wr_txn(32'h2004, 32'hC0DE_1004));
      exp_q.push_back(rd_txn(32'h1008)); exp_q.push_back(wr_txn(32'h2008, 32'hC0DE_1008));
      exp_done_q.push_back({1'b0, 16'd3});
      start_copy(32'h1000, 32'h2000, 3);
      wait_done(lat, reqs, bz);
      check("zw_latency", 65'(lat), 65'd13);
      idle(1);
      check("zw_mem0", {33'h0, rd_wmem(32'h2000)}, {33'h0, 32'hC0DE_1000});
      check("zw_mem1", {33'h0, rd_wmem(32'h2004)}, {33'h0, 32'hC0DE_1004});
      check("zw_mem2", {33'h0, rd_wmem(32'h2008)}, {33'h0, 32'hC0DE_1008});
      check("zw_busy_after", {64'h0, busy_o}, 65'h0);
      idle(2);

      // zero length
      exp_done_q.push_back({1'b0, 16'd0});
      start_copy(32'h1000, 32'h2000, 0);
      wait_done(lat, reqs, bz);
      check("len0_latency", 65'(lat), 65'd1);
      check("len0_no_req", 65'(reqs), 65'd0);
      check("len0_no_busy", {64'h0, bz}, 65'h0);
      idle(3);

      // slow responder, unaligned source bits ignored
      gnt_delay = 2;
      rv_delay  = 3;
      exp_q.push_back(rd_txn(32'h3000)); exp_q.push_back(wr_txn(32'h4000, 32'hC0DE_3000));
      exp_q.push_back(rd_txn(32'h3004)); exp_q.push_back(wr_txn(32'h4004, 32'hC0DE_3004));
      exp_done_q.push_back({1'b0, 16'd2});
      start_copy(32'h3002, 32'h4001, 2);
      wait_done(lat, reqs, bz);
      idle(1);
      check("slow_mem0", {33'h0, rd_wmem(32'h4000)}, {33'h0, 32'hC0DE_3000});
      check("slow_mem1", {33'h0, rd_wmem(32'h4004)}, {33'h0, 32'hC0DE_3004});
      gnt_delay = 0;
      rv_delay  = 0;
      idle(3);

      // error on second write
      err_on_wr = 2;
      exp_q.push_back(rd_txn(32'h5000)); exp_q.push_back(wr_txn(32'h6000, 32'hC0DE_5000));
      exp_q.push_back(rd_txn(32'h5004)); exp_q.push_back(wr_txn(32'h6004, 32'hC0DE_5004));
      exp_done_q.push_back({1'b1, 16'd1});
      start_copy(32'h5000, 32'h6000, 4);
      wait_done(lat, reqs, bz);
      idle(10);
      check("werr_no_req", {64'h0, bus.req}, 65'h0);
      check("werr_err_sticky", {64'h0, err_o}, 65'h1);
      err_on_wr = 0;

      // no grant ever: timeout
      never_gnt = 1'b1;
      exp_done_q.push_back({1'b1, 16'd0});
      start_copy(32'h1000, 32'h2000, 1);
      wait_done(lat, reqs, bz);
      check("tmo_req_cycles", 65'(reqs), 65'(TIMEOUT));
      idle(1);
      check("tmo_req_low", {64'h0, bus.req}, 65'h0);
      never_gnt = 1'b0;
      idle(2);
      exp_q.push_back(rd_txn(32'h1000)); exp_q.push_back(wr_txn(32'h7000, 32'hC0DE_1000));
      exp_done_q.push_back({1'b0, 16'd1});
      start_copy(32'h1000, 32'h7000, 1);
      check("tmo_err_cleared", {64'h0, err_o}, 65'h0);
      wait_done(lat, reqs, bz);
      idle(3);

      // reset during write wait of word 2
      exp_q.push_back(rd_txn(32'h8000)); exp_q.push_back(wr_txn(32'h9000, 32'hC0DE_8000));
      exp_q.push_back(rd_txn(32'h8004)); exp_q.push_back(wr_txn(32'h9004, 32'hC0DE_8004));
      start_copy(32'h8000, 32'h9000, 3);
      k = 0;
      while (!(dbg_state_o == 3'd4 && words_done_o == 16'd1) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("rst_mid_reached", {64'h0, (k < 100)}, 65'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstm_bus", {bus.req, bus.we, bus.addr, bus.wdata[30:0]}, 65'h0);
      check("rstm_flags", {62'h0, busy_o, done_o, err_o}, 65'h0);
      check("rstm_words", {49'h0, words_done_o}, 65'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);

      // address wrap
      exp_q.push_back(rd_txn(32'hFFFF_FFFC)); exp_q.push_back(wr_txn(32'hA000, 32'h3F21_FFFC));
      exp_q.push_back(rd_txn(32'h0000_0000)); exp_q.push_back(wr_txn(32'hA004, 32'hC0DE_0000));
      exp_done_q.push_back({1'b0, 16'd2});
      start_copy(32'hFFFF_FFFC, 32'hA000, 2);
      wait_done(lat, reqs, bz);
      idle(3);
      check("wrap_mem1", {33'h0, rd_wmem(32'hA004)}, {33'h0, 32'hC0DE_0000});

      // final report
      check("exp_txn_left", 65'(exp_q.size()), 65'd0);
      check("exp_done_left", 65'(exp_done_q.size()), 65'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator on the master end of bus_if; the counterpart to the memory-mapped peripheral responders on the same bus.
- Copies len_i 32-bit words from src_addr_i to dst_addr_i.
- Each word is one bus read followed by one bus write, with strictly one outstanding transaction.
- Used by the core-side glue to move result buffers into peripheral/shared memory without CPU load/store loops.

Parameters:
LEN_W, 16, width of the word-count input and progress counter
TIMEOUT, 256, cycles allowed waiting for gnt or rvalid before abort (must be >= 2)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  one-cycle start pulse; sampled only in IDLE
src_addr_i  input  32  source byte address, word aligned (bits[1:0] ignored, treated as 0)
dst_addr_i  input  32  destination byte address, word aligned (bits[1:0] ignored)
len_i  input  LEN_W  number of words to copy
busy_o  output  1  high from the cycle after accepted start until DONE
done_o  output  1  one-cycle pulse at end of copy, whether success or abort
err_o  output  1  sticky error flag; cleared on next accepted start
words_done_o  output  LEN_W  count of words fully written
bus  modport  -  bus_if.master
  - drives: req, we, addr[31:0], wdata[31:0]
  - samples: gnt, rvalid, rdata[31:0], err

Behaviour:
- Reset (rst_i high at clock edge) values: state=IDLE, bus.req=0, bus.we=0, bus.addr=0, bus.wdata=0, busy_o=0, done_o=0, err_o=0, words_done_o=0.
- Reset mid-copy aborts immediately, with no done_o pulse.
- All bus outputs are registered.
- Bus protocol, as master:
  - Assert req with stable addr/we/wdata until the cycle gnt=1; that cycle is the acceptance.
  - Deassert req in the cycle after acceptance.
  - Response is the first rvalid=1 after acceptance; rdata and err are valid only in that cycle.
  - Responders may assert gnt in the same cycle as req and rvalid exactly one cycle later; the master tolerates any number of wait cycles on both.
- FSM:
  - IDLE: on start_i, latch src/dst/len, clear err_o and words_done_o. Go to DONE if len_i==0, else RD_REQ.
  - RD_REQ: req=1, we=0, addr=src pointer; on gnt go to RD_WAIT.
  - RD_WAIT: on rvalid, capture rdata into the data register. If err, set err_o and go to DONE; else go to WR_REQ.
  - WR_REQ: req=1, we=1, addr=dst pointer, wdata=data register; on gnt go to WR_WAIT.
  - WR_WAIT: on rvalid:
    - If err, set err_o and go to DONE.
    - Else increment words_done_o, add 4 to both pointers (mod 2^32, wrap allowed), decrement the remaining count.
    - Go to DONE if remaining reaches 0, else RD_REQ.
  - DONE: done_o=1 for one cycle, busy_o=0, return to IDLE.
- busy_o is high in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT only.
- Throughput with a zero-wait responder: 4 cycles per word. First read req appears the cycle after start_i.
- Timeout: a counter resets on each state entry and counts cycles spent in RD_REQ/RD_WAIT/WR_REQ/WR_WAIT. At TIMEOUT it sets err_o, drops req and goes to DONE.
- start_i outside IDLE is ignored; a start pulse in the DONE cycle is also ignored.
- A partial copy leaves words_done_o at the number of successfully written words.

Test Plan:
- Zero-wait responder; src=0x1000, dst=0x2000, len=3, memory 0x1000..0x1008 = A,B,C:
  - A,B,C written to 0x2000..0x2008.
  - Bus sequence is exactly R,W,R,W,R,W.
  - done_o pulses 13 cycles after start, words_done_o=3, err_o=0.
- len=0 -> no req ever asserted, done_o pulses the cycle after start, busy_o stays 0.
- Responder inserts 2 cycles gnt delay and 3 cycles rvalid delay on every access:
  - addr/we/wdata held stable while req=1 and gnt=0.
  - Copy completes correctly with words_done_o=len.
- Responder returns err=1 on the 2nd write, len=4 -> err_o=1, words_done_o=1, done_o pulses, no further req.
- Responder never asserts gnt, TIMEOUT=16 -> req drops after 16 cycles, err_o=1, done_o pulses. The next start clears err_o.
- rst_i asserted during WR_WAIT of word 2 -> next cycle all outputs at reset values, no done_o. src=0xFFFFFFFC len=2 then reads 0xFFFFFFFC and 0x00000000 (wrap).
